// File: rtl/avg_pkg.sv
// Shared types and widths for the vector line queue and its rasterizer.
package avg_pkg;

  localparam int unsigned COORD_W = 13;
  localparam int unsigned INT_W   = 4;
  localparam int unsigned CUR_W   = 14;
  localparam int unsigned ERR_W   = 16;
  localparam int unsigned PIX_W   = 10;

  typedef struct packed {
    logic [COORD_W-1:0] start_x;
    logic [COORD_W-1:0] start_y;
    logic [COORD_W-1:0] end_x;
    logic [COORD_W-1:0] end_y;
    logic [INT_W-1:0]   intensity;
  } line_t;

  typedef enum logic [1:0] {
    RS_IDLE,
    RS_SETUP,
    RS_DRAW
  } raster_state_t;

  // Widen a queue coordinate into the stepper's signed coordinate space.
  function automatic logic signed [CUR_W-1:0] sext_coord(input logic [COORD_W-1:0] c);
    return {c[COORD_W-1], c};
  endfunction

endpackage

// File: rtl/bresenham_step.sv
// One all-octant Bresenham step: both axis updates are judged against the same e2.
module bresenham_step
  import avg_pkg::*;
(
  input  logic signed [CUR_W-1:0] cur_x_i,
  input  logic signed [CUR_W-1:0] cur_y_i,
  input  logic signed [CUR_W-1:0] end_x_i,
  input  logic signed [CUR_W-1:0] end_y_i,
  input  logic signed [ERR_W-1:0] err_i,
  input  logic signed [ERR_W-1:0] dx_i,
  input  logic signed [ERR_W-1:0] dy_i,
  input  logic                    sx_neg_i,
  input  logic                    sy_neg_i,
  output logic signed [CUR_W-1:0] cur_x_o,
  output logic signed [CUR_W-1:0] cur_y_o,
  output logic signed [ERR_W-1:0] err_o,
  output logic                    last_o
);

  logic signed [ERR_W-1:0] e2;
  logic signed [CUR_W-1:0] step_x;
  logic signed [CUR_W-1:0] step_y;

  assign e2     = err_i <<< 1;
  assign step_x = {CUR_W{sx_neg_i}} | CUR_W'(1);
  assign step_y = {CUR_W{sy_neg_i}} | CUR_W'(1);
  assign last_o = (cur_x_i == end_x_i) && (cur_y_i == end_y_i);

  always_comb begin
    cur_x_o = cur_x_i;
    cur_y_o = cur_y_i;
    err_o   = err_i;
    if (e2 >= dy_i) begin
      err_o   = err_o + dy_i;
      cur_x_o = cur_x_i + step_x;
    end
    if (e2 <= dx_i) begin
      err_o   = err_o + dx_i;
      cur_y_o = cur_y_i + step_y;
    end
  end

endmodule

// File: rtl/avg_line_raster.sv
// Pops lines from the vector queue and streams clipped Bresenham pixels to the
// framebuffer over a valid/ready handshake.
module avg_line_raster
  import avg_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int X_OFFSET = 320,
  parameter int Y_OFFSET = 240
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] QStartX,
  input  logic [COORD_W-1:0] QStartY,
  input  logic [COORD_W-1:0] QEndX,
  input  logic [COORD_W-1:0] QEndY,
  input  logic [INT_W-1:0]   QIntensity,
  input  logic               empty,
  output logic               read,
  output logic [PIX_W-1:0]   pixX,
  output logic [PIX_W-1:0]   pixY,
  output logic [INT_W-1:0]   pixColor,
  output logic               pixWrite,
  input  logic               pixReady,
  output logic               busy
);

  raster_state_t           state_q, state_d;
  line_t                   line_q, line_d;
  logic signed [CUR_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic signed [ERR_W-1:0] err_q, err_d, dx_q, dx_d, dy_q, dy_d;
  logic                    sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
  logic [PIX_W-1:0]        pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [INT_W-1:0]        pix_color_q, pix_color_d;
  logic                    pix_write_q, pix_write_d;
  logic                    busy_q;
  logic                    load;

  logic signed [CUR_W-1:0] x0, y0, x1, y1;
  logic signed [ERR_W-1:0] diff_x, diff_y, abs_x, abs_y;
  logic signed [CUR_W-1:0] nxt_x, nxt_y, tgt_x, tgt_y;
  logic signed [ERR_W-1:0] nxt_err;
  logic                    last;
  logic signed [ERR_W-1:0] px, py;
  logic                    on_screen;

  assign x0 = sext_coord(line_q.start_x);
  assign y0 = sext_coord(line_q.start_y);
  assign x1 = sext_coord(line_q.end_x);
  assign y1 = sext_coord(line_q.end_y);

  assign diff_x = ERR_W'(x1) - ERR_W'(x0);
  assign diff_y = ERR_W'(y1) - ERR_W'(y0);
  assign abs_x  = diff_x[ERR_W-1] ? -diff_x : diff_x;
  assign abs_y  = diff_y[ERR_W-1] ? -diff_y : diff_y;

  bresenham_step u_step (
    .cur_x_i  (cur_x_q),
    .cur_y_i  (cur_y_q),
    .end_x_i  (x1),
    .end_y_i  (y1),
    .err_i    (err_q),
    .dx_i     (dx_q),
    .dy_i     (dy_q),
    .sx_neg_i (sx_neg_q),
    .sy_neg_i (sy_neg_q),
    .cur_x_o  (nxt_x),
    .cur_y_o  (nxt_y),
    .err_o    (nxt_err),
    .last_o   (last)
  );

  // The point about to be presented: the start point out of SETUP, else the next step.
  assign tgt_x     = (state_q == RS_SETUP) ? x0 : nxt_x;
  assign tgt_y     = (state_q == RS_SETUP) ? y0 : nxt_y;
  assign px        = ERR_W'(tgt_x) + ERR_W'(X_OFFSET);
  assign py        = ERR_W'(Y_OFFSET) - ERR_W'(tgt_y);
  assign on_screen = !px[ERR_W-1] && (px < ERR_W'(SCREEN_W)) &&
                     !py[ERR_W-1] && (py < ERR_W'(SCREEN_H));

  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    cur_x_d     = cur_x_q;
    cur_y_d     = cur_y_q;
    err_d       = err_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    sx_neg_d    = sx_neg_q;
    sy_neg_d    = sy_neg_q;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    pix_write_d = pix_write_q;
    read        = 1'b0;
    load        = 1'b0;

    unique case (state_q)
      RS_IDLE: begin
        pix_write_d = 1'b0;
        if (!empty && !rst) begin
          read             = 1'b1;
          line_d.start_x   = QStartX;
          line_d.start_y   = QStartY;
          line_d.end_x     = QEndX;
          line_d.end_y     = QEndY;
          line_d.intensity = QIntensity;
          state_d          = RS_SETUP;
        end
      end
      RS_SETUP: begin
        dx_d     = abs_x;
        dy_d     = -abs_y;
        sx_neg_d = diff_x[ERR_W-1];
        sy_neg_d = diff_y[ERR_W-1];
        err_d    = abs_x - abs_y;
        cur_x_d  = x0;
        cur_y_d  = y0;
        if (line_q.intensity == '0) begin
          state_d = RS_IDLE;
        end else begin
          state_d = RS_DRAW;
          load    = 1'b1;
        end
      end
      RS_DRAW: begin
        // Off-screen points never wait for the framebuffer.
        if (!pix_write_q || pixReady) begin
          if (last) begin
            state_d     = RS_IDLE;
            pix_write_d = 1'b0;
          end else begin
            cur_x_d = nxt_x;
            cur_y_d = nxt_y;
            err_d   = nxt_err;
            load    = 1'b1;
          end
        end
      end
      default: state_d = RS_IDLE;
    endcase

    if (load) begin
      pix_write_d = on_screen;
      if (on_screen) begin
        pix_x_d     = px[PIX_W-1:0];
        pix_y_d     = py[PIX_W-1:0];
        pix_color_d = line_q.intensity;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RS_IDLE;
      line_q      <= '0;
      cur_x_q     <= '0;
      cur_y_q     <= '0;
      err_q       <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      sx_neg_q    <= 1'b0;
      sy_neg_q    <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
      pix_write_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      cur_x_q     <= cur_x_d;
      cur_y_q     <= cur_y_d;
      err_q       <= err_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      sx_neg_q    <= sx_neg_d;
      sy_neg_q    <= sy_neg_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      pix_write_q <= pix_write_d;
      busy_q      <= (state_d != RS_IDLE);
    end
  end

  assign pixX     = pix_x_q;
  assign pixY     = pix_y_q;
  assign pixColor = pix_color_q;
  assign pixWrite = pix_write_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_avg_line_raster.sv
// Bench for avg_line_raster: queue model feeding lines, scoreboard of expected pixels.
module tb_avg_line_raster;
  import avg_pkg::*;

  typedef struct {
    int sx, sy, ex, ey, inten;
    int npix;
    int active;
    bit tog;
  } vec_t;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] QStartX, QStartY, QEndX, QEndY;
  logic [3:0]  QIntensity;
  logic        empty;
  logic        read;
  logic [9:0]  pixX, pixY;
  logic [3:0]  pixColor;
  logic        pixWrite;
  logic        pixReady;
  logic        busy;

  avg_line_raster dut (
    .clk        (clk),
    .rst        (rst),
    .QStartX    (QStartX),
    .QStartY    (QStartY),
    .QEndX      (QEndX),
    .QEndY      (QEndY),
    .QIntensity (QIntensity),
    .empty      (empty),
    .read       (read),
    .pixX       (pixX),
    .pixY       (pixY),
    .pixColor   (pixColor),
    .pixWrite   (pixWrite),
    .pixReady   (pixReady),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  vec_t  vtab[$];
  pix_t  ptab[$];
  line_t linq[$];
  pix_t  expq[$];

  int n_vec = 0;
  int n_miss = 0;
  int n_xfer, n_read, n_active, cyc_phase;
  bit ready_toggle;
  bit idle_seen;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add_vec(input int sx, sy, ex, ey, inten, npix, active, input bit tog);
    vec_t v;
    v.sx = sx; v.sy = sy; v.ex = ex; v.ey = ey; v.inten = inten;
    v.npix = npix; v.active = active; v.tog = tog;
    vtab.push_back(v);
  endtask

  task automatic add_pix(input int x, y, c);
    pix_t p;
    p.x = x; p.y = y; p.c = c;
    ptab.push_back(p);
  endtask

  task automatic exp_pix(input int x, y, c);
    pix_t p;
    p.x = x; p.y = y; p.c = c;
    expq.push_back(p);
  endtask

  task automatic drive_q();
    if (linq.size() == 0) begin
      empty = 1'b1;
      QStartX = '0; QStartY = '0; QEndX = '0; QEndY = '0; QIntensity = '0;
    end else begin
      empty = 1'b0;
      QStartX    = linq[0].start_x;
      QStartY    = linq[0].start_y;
      QEndX      = linq[0].end_x;
      QEndY      = linq[0].end_y;
      QIntensity = linq[0].intensity;
    end
  endtask

  task automatic push_line(input int sx, sy, ex, ey, inten);
    line_t l;
    l.start_x   = 13'(sx);
    l.start_y   = 13'(sy);
    l.end_x     = 13'(ex);
    l.end_y     = 13'(ey);
    l.intensity = 4'(inten);
    linq.push_back(l);
    drive_q();
  endtask

  task automatic clr_counts();
    n_xfer = 0; n_read = 0; n_active = 0;
  endtask

  // One clock: observe at the falling edge, update the queue model after the rising edge.
  task automatic tick();
    bit do_pop;
    @(negedge clk);
    do_pop = read;
    if (read) begin
      n_read++;
      chk("read_while_empty", int'(empty), 0);
      chk("read_outside_idle", int'(busy), 0);
    end
    if (busy || read) n_active++;
    if (pixWrite) begin
      if (expq.size() == 0) begin
        chk("unexpected_pixel", 1, 0);
      end else begin
        chk("pix_x", int'(pixX), expq[0].x);
        chk("pix_y", int'(pixY), expq[0].y);
        chk("pix_color", int'(pixColor), expq[0].c);
        if (pixReady) begin
          void'(expq.pop_front());
          n_xfer++;
        end
      end
    end
    idle_seen = !busy && !read && !pixWrite;
    @(posedge clk);
    #1;
    if (do_pop && linq.size() > 0) void'(linq.pop_front());
    drive_q();
    cyc_phase++;
    pixReady = ready_toggle ? ((cyc_phase % 3) == 0) : 1'b1;
  endtask

  task automatic run_until_idle(input int budget);
    int k;
    k = 0;
    idle_seen = 1'b0;
    do begin
      tick();
      k++;
    end while (!(idle_seen && linq.size() == 0) && k < budget);
    if (!(idle_seen && linq.size() == 0)) chk("idle_timeout", k, -1);
    chk("leftover_expected", expq.size(), 0);
  endtask

  initial begin
    int off;
    rst = 1'b1;
    pixReady = 1'b1;
    ready_toggle = 1'b0;
    cyc_phase = 0;
    drive_q();

    add_vec(0, 0, 3, 1, 7, 4, 6, 1'b0);
    add_pix(320, 240, 7); add_pix(321, 240, 7); add_pix(322, 239, 7); add_pix(323, 239, 7);
    add_vec(5, -5, 5, -5, 3, 1, 3, 1'b0);
    add_pix(325, 245, 3);
    add_vec(0, 0, 10, -7, 0, 0, 2, 1'b0);
    add_vec(-330, 0, -315, 0, 5, 6, 18, 1'b0);
    for (int i = 0; i < 6; i++) add_pix(i, 240, 5);
    add_vec(319, -239, 320, -240, 15, 1, 4, 1'b0);
    add_pix(639, 479, 15);
    add_vec(0, 0, 1, 4, 9, 5, -1, 1'b1);
    add_pix(320, 240, 9); add_pix(320, 239, 9); add_pix(321, 238, 9);
    add_pix(321, 237, 9); add_pix(321, 236, 9);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_read", int'(read), 0);
    chk("rst_pixWrite", int'(pixWrite), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_pixX", int'(pixX), 0);
    chk("idle_pixY", int'(pixY), 0);
    chk("idle_pixColor", int'(pixColor), 0);

    off = 0;
    foreach (vtab[i]) begin
      ready_toggle = vtab[i].tog;
      cyc_phase = 0;
      pixReady = 1'b1;
      clr_counts();
      push_line(vtab[i].sx, vtab[i].sy, vtab[i].ex, vtab[i].ey, vtab[i].inten);
      for (int k = 0; k < vtab[i].npix; k++) expq.push_back(ptab[off + k]);
      off += vtab[i].npix;
      run_until_idle(200);
      chk($sformatf("vec%0d_writes", i), n_xfer, vtab[i].npix);
      chk($sformatf("vec%0d_reads", i), n_read, 1);
      if (vtab[i].active >= 0) chk($sformatf("vec%0d_cycles", i), n_active, vtab[i].active);
    end
    ready_toggle = 1'b0;
    pixReady = 1'b1;

    // Three queued lines drawn back to back in FIFO order.
    clr_counts();
    push_line(0, 0, 2, 0, 1);
    push_line(-1, 1, -1, -1, 2);
    push_line(2, 2, 0, 0, 4);
    exp_pix(320, 240, 1); exp_pix(321, 240, 1); exp_pix(322, 240, 1);
    exp_pix(319, 239, 2); exp_pix(319, 240, 2); exp_pix(319, 241, 2);
    exp_pix(322, 238, 4); exp_pix(321, 239, 4); exp_pix(320, 240, 4);
    run_until_idle(200);
    chk("fifo_reads", n_read, 3);
    chk("fifo_writes", n_xfer, 9);
    chk("fifo_cycles", n_active, 15);

    // Reset while the third pixel of a long line is presented.
    clr_counts();
    push_line(0, 0, 20, 0, 6);
    exp_pix(320, 240, 6); exp_pix(321, 240, 6); exp_pix(322, 240, 6);
    for (int k = 0; k < 20 && n_xfer < 2; k++) tick();
    chk("reset_reach_third", n_xfer, 2);
    rst = 1'b1;
    pixReady = 1'b0;
    tick();
    rst = 1'b0;
    chk("midrst_pixWrite", int'(pixWrite), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_read", int'(read), 0);
    chk("midrst_pixX", int'(pixX), 0);
    chk("midrst_pixY", int'(pixY), 0);
    chk("midrst_pixColor", int'(pixColor), 0);
    expq.delete();

    clr_counts();
    push_line(0, -1, 1, -1, 8);
    exp_pix(320, 241, 8); exp_pix(321, 241, 8);
    run_until_idle(100);
    chk("after_rst_reads", n_read, 1);
    chk("after_rst_writes", n_xfer, 2);
    chk("after_rst_cycles", n_active, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/avg_line_raster.md
# avg_line_raster

Consumer end of the vector line queue. It pops line segments (start/end coordinates and intensity) from the line register queue written by the AVG core, and rasterizes each with an all-octant Bresenham stepper. It emits one framebuffer pixel write per cycle under a valid/ready handshake. It sits between the line queue and the framebuffer write port.

## Interface
Parameters:
- `SCREEN_W`, 640: visible pixel columns.
- `SCREEN_H`, 480: visible pixel rows.
- `X_OFFSET`, 320: pixel column of vector X = 0.
- `Y_OFFSET`, 240: pixel row of vector Y = 0. Vector +Y is up the screen.

Ports:
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `QStartX`, `QStartY`, `QEndX`, `QEndY` in 13: queue head line, two's-complement, combinational from the queue.
- `QIntensity` in 4: queue head intensity.
- `empty` in 1: queue has no lines.
- `read` out 1: pop strobe, one cycle per line; reset 0.
- `pixX` out 10: pixel column; reset 0.
- `pixY` out 10: pixel row; reset 0.
- `pixColor` out 4: pixel intensity; reset 0.
- `pixWrite` out 1: pixel valid; reset 0.
- `pixReady` in 1: framebuffer accepts the pixel this cycle.
- `busy` out 1: state is not IDLE; reset 0.

## Operation
- States: IDLE, SETUP, DRAW.
- IDLE:
  - If `~empty`: assert `read` combinationally, capture all Q* fields at this edge, go to SETUP.
  - Otherwise stay in IDLE.
- SETUP (1 cycle):
  - dx = |x1-x0|, dy = -|y1-y0|.
  - sx = sign(x1-x0), sy = sign(y1-y0); a sign of 0 is treated as +1.
  - err = dx + dy; cur = (x0, y0).
  - If the captured intensity is 0, the line is blank: return to IDLE and emit no pixels.
  - Otherwise go to DRAW.
- DRAW, per step:
  - Map the current point to the screen: px = curX + X_OFFSET, py = Y_OFFSET - curY.
  - If 0 <= px < SCREEN_W and 0 <= py < SCREEN_H: drive `pixWrite` = 1 with `pixX`/`pixY`/`pixColor`, hold them stable, and advance only on `pixWrite && pixReady`.
  - If the point is off-screen: `pixWrite` = 0 and the stepper advances unconditionally that cycle (clipping).
  - Step update: e2 = 2*err. If e2 >= dy: err += dy, curX += sx. If e2 <= dx: err += dx, curY += sy. Both updates are evaluated against the same e2.
  - After the step that consumes the end point (cur == end), go to IDLE.
- Arithmetic:
  - Internal coordinates are 14-bit signed; the 13-bit inputs are sign-extended.
  - err and e2 are 16-bit signed.
  - px/py are computed in 16-bit signed, then bounds-checked before truncation to 10 bits.
- Degenerate line (start == end): exactly one pixel.
- Reset mid-line: the line is abandoned and not re-read. The next cycle has `pixWrite` = 0 and `read` = 0, and the state is IDLE.
- `read` is never asserted while `empty` = 1, and never asserted outside IDLE.

## Timing
- Pop to first pixel valid: 2 cycles (read edge, then SETUP edge).
- Throughput: 1 pixel/cycle while `pixReady` = 1. A line with N drawn points takes N+2 cycles, plus stall cycles.
- Back-to-back lines: after the last-pixel transfer, the state is IDLE for one cycle, during which `read` can assert.
- `pixWrite`/`pixX`/`pixY`/`pixColor` are registered and change only after a transfer or on a state change.
- `pixReady` is ignored when `pixWrite` = 0.

## Structure
- Shared package `avg_pkg`:
  - `line_t` struct: startX, startY, endX, endY, intensity.
  - `raster_state_t` enum.
  - Width constants: COORD_W = 13, INT_W = 4.
- Natural sub-module: `bresenham_step`, a combinational next-state function (cur, err, dx, dy, sx, sy, end) -> (cur', err', last).
- Everything else (FSM, capture registers, output registers, clip check) lives in `avg_line_raster`.

## Test plan
- Line (0,0)-(3,1), intensity 7, pixReady tied 1 -> exactly 4 writes: (320,240), (321,240), (322,239), (323,239), each with color 7. One `read` pulse. Idle after 6 cycles.
- Point line (5,-5)-(5,-5), intensity 3 -> single write (325,245). Intensity 0 line of any length -> `read` pulses, zero writes, `busy` drops after 2 cycles.
- Line (-330,0)-(-315,0) -> only x = -320..-315 are written, as pixX 0..5. The 10 off-screen points produce no writes. 16 stepping cycles total.
- pixReady toggling 1,0,0,1,... on a steep line (0,0)-(1,4) -> outputs held stable during stalls. Writes in order (320,240), (320,239), (321,238), (321,237), (321,236); no duplicates, none dropped.
- Queue with 3 lines, empty deasserted -> exactly 3 `read` pulses, each while `empty` = 0 and in IDLE. Lines are drawn in FIFO order.
- `rst` asserted during the 3rd pixel of a long line -> next cycle `pixWrite` = 0, `busy` = 0, all outputs at reset values. The line is not resumed. The next queued line starts cleanly.
